bp_me_burst_lock_arbiter: RTL and testbench



---
 rtl/bp_me_burst_lock_arbiter.sv | 108 ++++++++++
 tb/tb_bp_me_burst_lock_arbiter.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_burst_lock_arbiter.sv
// bp_me_burst_lock_arbiter: round-robin arbiter locking one BedRock Burst output for a whole message.
// Define BP_ME_BURST_ARB_FASTPATH_EN to pick and forward the winning header combinationally from idle.
module bp_me_burst_lock_arbiter #(
    parameter int paddr_width_p       = 40
   ,parameter int num_req_p           = 2
   ,parameter int stream_data_width_p = 64
   ,parameter int payload_width_p     = 32
   ,localparam int xce_header_width_lp = 11 + paddr_width_p + payload_width_p
   ,localparam int lg_req_lp           = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                                       clk_i
   ,input  logic                                       reset_n_i
   ,input  logic [num_req_p*xce_header_width_lp-1:0]   msg_header_i
   ,input  logic [num_req_p-1:0]                       msg_header_v_i
   ,output logic [num_req_p-1:0]                       msg_header_ready_and_o
   ,input  logic [num_req_p-1:0]                       msg_has_data_i
   ,input  logic [num_req_p*stream_data_width_p-1:0]   msg_data_i
   ,input  logic [num_req_p-1:0]                       msg_data_v_i
   ,output logic [num_req_p-1:0]                       msg_data_ready_and_o
   ,input  logic [num_req_p-1:0]                       msg_last_i
   ,output logic [xce_header_width_lp-1:0]             out_header_o
   ,output logic                                       out_header_v_o
   ,input  logic                                       out_header_ready_and_i
   ,output logic                                       out_has_data_o
   ,output logic [stream_data_width_p-1:0]             out_data_o
   ,output logic                                       out_data_v_o
   ,input  logic                                       out_data_ready_and_i
   ,output logic                                       out_last_o
   ,output logic [lg_req_lp-1:0]                       grant_id_o
   ,output logic                                       lock_o
);
   typedef enum logic [1:0] {e_idle, e_header, e_data} state_e;
   state_e state_r, state_n;
   logic [lg_req_lp-1:0] grant_r, grant_n, last_r, last_n, pick, sel, idx;
   logic any_v;
   assign any_v = |msg_header_v_i;
   // Scan from farthest to nearest so the first valid requester after last_r is written last and wins
   always_comb begin
      pick = '0;
      idx = '0;
      for (int i = num_req_p; i >= 1; i--) begin
         idx = lg_req_lp'((int'(last_r) + i) % num_req_p);
         if (msg_header_v_i[idx]) pick = idx;
      end
   end
   always_comb begin
      state_n = state_r;
      grant_n = grant_r;
      last_n = last_r;
      sel = grant_r;
      out_header_v_o = 1'b0;
      out_data_v_o = 1'b0;
      msg_header_ready_and_o = '0;
      msg_data_ready_and_o = '0;
      case (state_r)
         e_header: begin
            out_header_v_o = msg_header_v_i[grant_r];
            msg_header_ready_and_o[grant_r] = out_header_ready_and_i;
            if (out_header_v_o & out_header_ready_and_i) begin
               last_n = grant_r;
               state_n = msg_has_data_i[grant_r] ? e_data : e_idle;
            end
         end
         e_data: begin
            out_data_v_o = msg_data_v_i[grant_r];
            msg_data_ready_and_o[grant_r] = out_data_ready_and_i;
            if (out_data_v_o & out_data_ready_and_i & msg_last_i[grant_r]) state_n = e_idle;
         end
         default: begin
`ifdef BP_ME_BURST_ARB_FASTPATH_EN
            // Without a same-cycle handshake the pick is parked in e_header so the offered header stays stable
            sel = pick;
            out_header_v_o = any_v & reset_n_i;
            msg_header_ready_and_o[pick] = out_header_ready_and_i & reset_n_i;
            if (any_v) begin
               grant_n = pick;
               state_n = e_header;
               if (out_header_ready_and_i) begin
                  last_n = pick;
                  state_n = msg_has_data_i[pick] ? e_data : e_idle;
               end
            end
`else
            if (any_v) begin
               grant_n = pick;
               state_n = e_header;
            end
`endif
         end
      endcase
   end
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         state_r <= e_idle;
         grant_r <= '0;
         last_r <= lg_req_lp'(num_req_p - 1);
      end else begin
         state_r <= state_n;
         grant_r <= grant_n;
         last_r <= last_n;
      end
   assign out_header_o = msg_header_i[sel*xce_header_width_lp+:xce_header_width_lp];
   assign out_has_data_o = msg_has_data_i[sel];
   assign out_data_o = msg_data_i[grant_r*stream_data_width_p+:stream_data_width_p];
   assign out_last_o = msg_last_i[grant_r];
   assign grant_id_o = grant_r;
   assign lock_o = (state_r != e_idle);
endmodule

// File: tb/tb_bp_me_burst_lock_arbiter.sv
// tb_bp_me_burst_lock_arbiter: directed scenarios plus randomized traffic against a message-level round-robin model.
module tb_bp_me_burst_lock_arbiter;
   localparam int N = 3;
   localparam int AW = 8;
   localparam int PW = 8;
   localparam int DW = 16;
   localparam int HW = 11 + AW + PW;
   localparam int M = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic [N*HW-1:0] hdr;
   logic [N-1:0] hv, hrdy, hasd, dv, drdy, lst;
   logic [N*DW-1:0] dat;
   logic [HW-1:0] ohdr;
   logic ohv, ohr, ohd, odv, odr, olst, lock;
   logic [DW-1:0] odat;
   logic [1:0] gid;
   int checks = 0;
   int errors = 0;

   logic [HW-1:0] hm [N][M];
   logic hdm [N][M];
   int nbm [N][M];
   logic [DW-1:0] db [N][M];
   int seq [64];
   int nseq;

   always #5 clk = ~clk;

   bp_me_burst_lock_arbiter #(
       .paddr_width_p(AW)
      ,.num_req_p(N)
      ,.stream_data_width_p(DW)
      ,.payload_width_p(PW)
   ) dut (
       .clk_i(clk)
      ,.reset_n_i(reset_n)
      ,.msg_header_i(hdr)
      ,.msg_header_v_i(hv)
      ,.msg_header_ready_and_o(hrdy)
      ,.msg_has_data_i(hasd)
      ,.msg_data_i(dat)
      ,.msg_data_v_i(dv)
      ,.msg_data_ready_and_o(drdy)
      ,.msg_last_i(lst)
      ,.out_header_o(ohdr)
      ,.out_header_v_o(ohv)
      ,.out_header_ready_and_i(ohr)
      ,.out_has_data_o(ohd)
      ,.out_data_o(odat)
      ,.out_data_v_o(odv)
      ,.out_data_ready_and_i(odr)
      ,.out_last_o(olst)
      ,.grant_id_o(gid)
      ,.lock_o(lock)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, required the bench to finish");
      $fatal(1);
   end

   task automatic clr();
      hdr = '0; hv = '0; hasd = '0; dat = '0; dv = '0; lst = '0; ohr = 1'b0; odr = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset_n = 1'b0;
      clr();
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   // Message-level model: every downstream header handshake must come from the first requester after the
   // previous owner that still has messages, and its beats must follow in order with last on the final beat.
   task automatic run_traffic(input int nmsg, input logic [N-1:0] act, input int hd_mode,
                              input int beats, input bit rnd, output int cycles);
      int hp[N], dp[N], dbt[N], mh[N];
      bit dvh[N];
      int m_last, m_owner, m_msg, m_beat, done, total, e, c;
      bit m_data;
      logic [N-1:0] own;
      total = 0;
      for (int i = 0; i < N; i++) begin
         hp[i] = 0; dp[i] = 0; dbt[i] = 0; mh[i] = 0; dvh[i] = 1'b0;
         for (int m = 0; m < nmsg; m++) begin
            hm[i][m] = HW'({$urandom, $urandom});
            hdm[i][m] = (hd_mode == 2) ? 1'($urandom_range(0, 1)) : (hd_mode == 1);
            nbm[i][m] = (beats > 0) ? beats : int'($urandom_range(1, 6));
            db[i][m] = DW'($urandom);
         end
         if (act[i]) total += nmsg;
      end
      m_last = N - 1; m_owner = 0; m_msg = 0; m_beat = 0; m_data = 1'b0; done = 0; nseq = 0; cycles = 0;
      do_reset();
      while (done < total && cycles < 3000) begin
         for (int i = 0; i < N; i++) begin
            while (dp[i] < hp[i] && !hdm[i][dp[i]]) dp[i]++;
            hv[i] = act[i] && hp[i] < nmsg;
            hdr[i*HW+:HW] = hm[i][(hp[i] < nmsg) ? hp[i] : 0];
            hasd[i] = hdm[i][(hp[i] < nmsg) ? hp[i] : 0];
            dv[i] = (dp[i] < hp[i]) && (dvh[i] || !rnd || $urandom_range(0, 3) != 0);
            dvh[i] = dv[i];
            dat[i*DW+:DW] = db[i][(dp[i] < nmsg) ? dp[i] : 0] + DW'(dbt[i]);
            lst[i] = (dbt[i] == nbm[i][(dp[i] < nmsg) ? dp[i] : 0] - 1);
         end
         ohr = !rnd || $urandom_range(0, 3) != 0;
         odr = !rnd || $urandom_range(0, 3) != 0;
         @(negedge clk);
         cycles++;
         own = m_data ? (N'(1) << m_owner) : '0;
         checks++;
         if ((m_data ? ohv : odv) !== 1'b0 || (m_data && lock !== 1'b1) || (drdy & ~own) !== '0 || (m_data && hrdy !== '0)) begin
            errors++;
            $display("FAIL phase: in_data=%0d hdr_v=%b data_v=%b lock=%b hrdy=%b drdy=%b, required only owner's active phase", m_data, ohv, odv, lock, hrdy, drdy);
         end
         if (ohv && ohr && !m_data) begin
            e = -1;
            for (int k = N; k >= 1; k--) begin
               c = (m_last + k) % N;
               if (act[c] && mh[c] < nmsg) e = c;
            end
            checks++;
            if (e < 0 || gid !== 2'(e)) begin
               errors++;
               $display("FAIL grant: got %0d, required %0d", gid, e);
            end
            if (e >= 0) begin
               checks++;
               if (ohdr !== hm[e][mh[e]]) begin
                  errors++;
                  $display("FAIL header: got %h, required %h", ohdr, hm[e][mh[e]]);
               end
               checks++;
               if (ohd !== hdm[e][mh[e]]) begin
                  errors++;
                  $display("FAIL has_data: got %b, required %b", ohd, hdm[e][mh[e]]);
               end
               seq[nseq] = e;
               if (nseq < 63) nseq++;
               m_last = e; m_owner = e; m_msg = mh[e]; mh[e]++; m_beat = 0;
               if (hdm[e][m_msg]) m_data = 1'b1; else done++;
            end
         end else if (odv && odr && m_data) begin
            checks++;
            if (odat !== db[m_owner][m_msg] + DW'(m_beat)) begin
               errors++;
               $display("FAIL data: got %h, required %h", odat, db[m_owner][m_msg] + DW'(m_beat));
            end
            checks++;
            if (olst !== (m_beat == nbm[m_owner][m_msg] - 1)) begin
               errors++;
               $display("FAIL last: got %b on beat %0d of %0d", olst, m_beat, nbm[m_owner][m_msg]);
            end
            m_beat++;
            if (m_beat == nbm[m_owner][m_msg]) begin
               m_data = 1'b0;
               done++;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (hv[i] && hrdy[i]) hp[i]++;
            if (dv[i] && drdy[i]) begin
               dvh[i] = 1'b0;
               if (lst[i]) begin
                  dbt[i] = 0;
                  dp[i]++;
               end else dbt[i]++;
            end
         end
         @(posedge clk); #1;
      end
      checks++;
      if (done != total) begin
         errors++;
         $display("FAIL traffic_timeout: completed %0d messages, required %0d", done, total);
      end
      clr();
   endtask

   task automatic test_reset();
      clr();
      hv = '1; hasd = '1; dv = '1; lst = '1; ohr = 1'b1; odr = 1'b1;
      #3 reset_n = 1'b0;
      #1;
      checks++;
      if ({ohv, odv, lock} !== 3'b000) begin
         errors++;
         $display("FAIL reset_valid: hdr_v/data_v/lock=%b, required 000", {ohv, odv, lock});
      end
      checks++;
      if ({hrdy, drdy} !== '0) begin
         errors++;
         $display("FAIL reset_ready: hrdy=%b drdy=%b, required 0", hrdy, drdy);
      end
      checks++;
      if (gid !== 2'd0) begin
         errors++;
         $display("FAIL reset_grant: got %0d, required 0", gid);
      end
      @(posedge clk); #1;
      checks++;
      if ({ohv, lock} !== 2'b00) begin
         errors++;
         $display("FAIL reset_hold: hdr_v/lock=%b across clock edge, required 00", {ohv, lock});
      end
      reset_n = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (ohv !== 1'b1 || gid !== 2'd0) begin
         errors++;
         $display("FAIL reset_priority: hdr_v=%b grant=%0d, required 1 and 0", ohv, gid);
      end
      clr();
   endtask

   task automatic test_header_only();
      logic [HW-1:0] h;
      h = HW'({$urandom, $urandom});
      do_reset();
      hv = 3'b001; hdr[0+:HW] = h; ohr = 1'b1;
      @(negedge clk);
      checks++;
      if (ohv !== 1'b0 || lock !== 1'b0) begin
         errors++;
         $display("FAIL latency_t0: hdr_v=%b lock=%b in arbitration cycle, required 0 0", ohv, lock);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (ohv !== 1'b1 || ohdr !== h || gid !== 2'd0 || lock !== 1'b1) begin
         errors++;
         $display("FAIL latency_t1: hdr_v=%b hdr=%h grant=%0d lock=%b, required 1 %h 0 1", ohv, ohdr, gid, lock, h);
      end
      checks++;
      if (hrdy !== 3'b001) begin
         errors++;
         $display("FAIL hdr_ready: got %b, required 001", hrdy);
      end
      @(posedge clk); #1;
      hv = 3'b000;
      @(negedge clk);
      checks++;
      if (lock !== 1'b0 || ohv !== 1'b0) begin
         errors++;
         $display("FAIL unlock: lock=%b hdr_v=%b after handshake, required 0 0", lock, ohv);
      end
      @(posedge clk); #1;
      hv = 3'b011;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (gid !== 2'd1) begin
         errors++;
         $display("FAIL last_update: grant %0d after req0 owned, required 1", gid);
      end
      clr();
   endtask

   task automatic test_rr_pair();
      int cyc;
      run_traffic(2, 3'b011, 1, 4, 1'b0, cyc);
      checks++;
      if (nseq != 4 || seq[0] != 0 || seq[1] != 1 || seq[2] != 0 || seq[3] != 1) begin
         errors++;
         $display("FAIL pair_order: got %0d msgs %0d,%0d,%0d,%0d, required 0,1,0,1", nseq, seq[0], seq[1], seq[2], seq[3]);
      end
      checks++;
      if (cyc != 24) begin
         errors++;
         $display("FAIL data_throughput: %0d cycles, required 24", cyc);
      end
   endtask

   task automatic test_three_rotate();
      int cyc;
      run_traffic(2, 3'b111, 0, 1, 1'b0, cyc);
      checks++;
      if (nseq != 6 || seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 0 || seq[4] != 1 || seq[5] != 2) begin
         errors++;
         $display("FAIL rotate_order: got %0d msgs %0d,%0d,%0d,%0d, required 0,1,2,0", nseq, seq[0], seq[1], seq[2], seq[3]);
      end
      checks++;
      if (cyc != 12) begin
         errors++;
         $display("FAIL hdr_throughput: %0d cycles, required 12", cyc);
      end
   endtask

   task automatic test_backpressure();
      logic [HW-1:0] h0, h1;
      logic [DW-1:0] b;
      int beat, cyc;
      h0 = HW'({$urandom, $urandom});
      h1 = HW'({$urandom, $urandom});
      b = DW'($urandom);
      do_reset();
      hv = 3'b001; hdr[0+:HW] = h0; ohr = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      hv = 3'b011; hdr[HW+:HW] = h1; hasd[1] = 1'b1; dv[1] = 1'b1; dat[DW+:DW] = b;
      @(negedge clk);
      checks++;
      if (drdy !== '0) begin
         errors++;
         $display("FAIL early_ready: drdy=%b before grant, required 000", drdy);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (ohv !== 1'b1 || gid !== 2'd1 || ohdr !== h1) begin
         errors++;
         $display("FAIL bp_grant: hdr_v=%b grant=%0d hdr=%h, required 1 1 %h", ohv, gid, ohdr, h1);
      end
      beat = 0;
      cyc = 0;
      while (beat < 8 && cyc < 40) begin
         @(posedge clk); #1;
         hv[1] = 1'b0;
         odr = cyc[0];
         dat[DW+:DW] = b + DW'(beat);
         lst[1] = (beat == 7);
         @(negedge clk);
         cyc++;
         checks++;
         if (drdy[0] !== 1'b0 || hrdy !== '0 || ohv !== 1'b0) begin
            errors++;
            $display("FAIL bp_isolation: drdy=%b hrdy=%b hdr_v=%b during req1 data, required no req0 handshake", drdy, hrdy, ohv);
         end
         if (odv && odr) begin
            checks++;
            if (odat !== b + DW'(beat) || olst !== (beat == 7)) begin
               errors++;
               $display("FAIL bp_beat: got %h last=%b, required %h last=%b", odat, olst, b + DW'(beat), beat == 7);
            end
            beat++;
         end
      end
      checks++;
      if (cyc != 16 || beat != 8) begin
         errors++;
         $display("FAIL bp_cycles: %0d beats in %0d cycles, required 8 in 16", beat, cyc);
      end
      @(posedge clk); #1;
      dv = '0; lst = '0; odr = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (ohv !== 1'b1 || gid !== 2'd0 || ohdr !== h0) begin
         errors++;
         $display("FAIL bp_next: hdr_v=%b grant=%0d hdr=%h, required 1 0 %h", ohv, gid, ohdr, h0);
      end
      clr();
   endtask

   task automatic test_reset_mid();
      do_reset();
      hv = 3'b001; hasd[0] = 1'b1; dv[0] = 1'b1; hdr[0+:HW] = HW'($urandom); dat[0+:DW] = DW'($urandom);
      ohr = 1'b1; odr = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (lock !== 1'b1 || odv !== 1'b1 || gid !== 2'd0) begin
         errors++;
         $display("FAIL mid_setup: lock=%b data_v=%b grant=%0d, required 1 1 0", lock, odv, gid);
      end
      @(posedge clk); #1;
      hv = 3'b011;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({ohv, odv, lock} !== 3'b000 || {hrdy, drdy} !== '0 || gid !== 2'd0) begin
         errors++;
         $display("FAIL mid_reset: v/lock=%b hrdy=%b drdy=%b grant=%0d, required all 0", {ohv, odv, lock}, hrdy, drdy, gid);
      end
      @(posedge clk); #1;
      hasd = '0; dv = '0;
      reset_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (ohv !== 1'b1 || gid !== 2'd0) begin
         errors++;
         $display("FAIL mid_priority: hdr_v=%b grant=%0d, required 1 0", ohv, gid);
      end
      clr();
   endtask

   task automatic test_early_data();
      logic [DW-1:0] b;
      b = DW'($urandom);
      do_reset();
      hv = 3'b001; hasd[0] = 1'b1; dv[0] = 1'b1; lst[0] = 1'b1; dat[0+:DW] = b; ohr = 1'b1; odr = 1'b1;
      @(negedge clk);
      checks++;
      if (drdy !== '0 || odv !== 1'b0) begin
         errors++;
         $display("FAIL early_idle: drdy=%b data_v=%b, required 0 0", drdy, odv);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (drdy !== '0 || odv !== 1'b0 || ohv !== 1'b1) begin
         errors++;
         $display("FAIL early_header: drdy=%b data_v=%b hdr_v=%b, required 0 0 1", drdy, odv, ohv);
      end
      @(posedge clk); #1;
      hv = '0;
      @(negedge clk);
      checks++;
      if (odv !== 1'b1 || drdy !== 3'b001 || odat !== b || olst !== 1'b1) begin
         errors++;
         $display("FAIL early_beat: data_v=%b drdy=%b data=%h last=%b, required 1 001 %h 1", odv, drdy, odat, olst, b);
      end
      @(posedge clk); #1;
      dv = '0;
      @(negedge clk);
      checks++;
      if (lock !== 1'b0) begin
         errors++;
         $display("FAIL early_done: lock=%b after last beat, required 0", lock);
      end
      clr();
   endtask

   task automatic test_random();
      int cyc;
      run_traffic(M, 3'b111, 2, 0, 1'b1, cyc);
      run_traffic(5, 3'b101, 2, 0, 1'b1, cyc);
      run_traffic(6, 3'b110, 1, 0, 1'b1, cyc);
   endtask

   initial begin
      test_reset();
      test_header_only();
      test_rr_pair();
      test_backpressure();
      test_three_rotate();
      test_reset_mid();
      test_early_data();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
